// File: rtl/vec_hazard_unit.sv
// Hazard control for the vector 5-stage pipe: forwarding, load-use, branch flush, multi-beat EX hold.
// Latency: all controls are combinational from inputs and FSM state; the beat FSM only sequences multi-beat ops.
// Backpressure: holds PC, IF/ID and ID/EX for ceil(VL/LANES)-1 cycles; VEC_HAZARD_PERF_CNT_EN adds stall/flush counters.
module vec_hazard_unit #(
    parameter int AW     = 4,
    parameter int NSRC   = 2,
    parameter int LANES  = 4,
    parameter int MAX_VL = 16,
    parameter int VLW    = $clog2(MAX_VL + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   ra_d,
    input  logic [NSRC-1:0]      src_valid_d,
    input  logic [NSRC*AW-1:0]   ra_e,
    input  logic [AW-1:0]        wa_e,
    input  logic [AW-1:0]        wa_m,
    input  logic [AW-1:0]        wa_w,
    input  logic                 memtoreg_e,
    input  logic                 regwrite_m,
    input  logic                 regwrite_w,
    input  logic                 vec_op_e,
    input  logic [VLW-1:0]       vl_e,
    input  logic                 branch_taken_e,
    output logic [2*NSRC-1:0]    forward_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_m,
    output logic                 ex_last
`ifdef VEC_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_count
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [VLW-1:0]  cnt, cnt_nxt;
    logic [VLW-1:0]  beats;
    logic [VLW:0]    vl_round;
    logic [VLW:0]    beats_full;
    logic            mc;
    logic            lu;

    always_comb begin
        forward_e = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (regwrite_m && ra_e[i*AW +: AW] == wa_m && ra_e[i*AW +: AW] != '0)
                forward_e[2*i +: 2] = 2'b10;
            else if (regwrite_w && ra_e[i*AW +: AW] == wa_w && ra_e[i*AW +: AW] != '0)
                forward_e[2*i +: 2] = 2'b01;
        end
    end

    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid_d[i] && ra_d[i*AW +: AW] == wa_e && ra_d[i*AW +: AW] != '0)
                lu = 1'b1;
        end
        lu = lu & memtoreg_e;
    end

    // Zero-length vectors still occupy EX for one beat.
    assign vl_round   = {1'b0, vl_e} + (VLW+1)'(LANES - 1);
    assign beats_full = vl_round / (VLW+1)'(LANES);
    assign beats      = (vl_e == '0) ? VLW'(1) : beats_full[VLW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc        = 1'b0;
        ex_last   = 1'b0;
        case (state)
            IDLE: begin
                if (vec_op_e) begin
                    if (beats > VLW'(1)) begin
                        cnt_nxt   = beats - VLW'(1);
                        state_nxt = BUSY;
                        mc        = 1'b1;
                    end else begin
                        ex_last = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt > VLW'(1)) begin
                    cnt_nxt = cnt - VLW'(1);
                    mc      = 1'b1;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    ex_last   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // An op caught by reset is abandoned at once, not drained.
        if (!rst_n) begin
            mc      = 1'b0;
            ex_last = 1'b0;
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (mc) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

`ifdef VEC_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_f && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if ((flush_e || flush_m) && flush_count != '1)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_hazard_unit.sv
// Directed bench for vec_hazard_unit with a beat-count reference model checked every cycle.
module tb_vec_hazard_unit;
    localparam int AW = 4, NSRC = 2, LANES = 4, MAX_VL = 16;
    localparam int VLW = $clog2(MAX_VL + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NSRC*AW-1:0] ra_d, ra_e;
    logic [NSRC-1:0] src_valid_d;
    logic [AW-1:0] wa_e, wa_m, wa_w;
    logic memtoreg_e, regwrite_m, regwrite_w, vec_op_e, branch_taken_e;
    logic [VLW-1:0] vl_e;
    logic [2*NSRC-1:0] forward_e;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, ex_last;
`ifdef VEC_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_chk = 0, n_fail = 0;
    int rem = 0;  // beats of the current vector op still to run, counting this cycle

    vec_hazard_unit #(.AW(AW), .NSRC(NSRC), .LANES(LANES), .MAX_VL(MAX_VL)) dut (
        .clk(clk), .rst_n(rst_n), .ra_d(ra_d), .src_valid_d(src_valid_d), .ra_e(ra_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w), .memtoreg_e(memtoreg_e),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .vec_op_e(vec_op_e),
        .vl_e(vl_e), .branch_taken_e(branch_taken_e), .forward_e(forward_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .flush_d(flush_d),
        .flush_e(flush_e), .flush_m(flush_m), .ex_last(ex_last)
`ifdef VEC_HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    wire [10:0] act = {forward_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, ex_last};

    function automatic int beats_of(int vl);
        if (vl == 0) return 1;
        return (vl + LANES - 1) / LANES;
    endfunction

    function automatic int cur_beats();
        if (rem > 0) return rem;
        if (vec_op_e) return beats_of(int'(vl_e));
        return 0;
    endfunction

    function automatic logic [10:0] model_out();
        logic [3:0] fwd;
        logic lu, mc, last, sf, sd, se, fd, fe, fm;
        int b, ra;
        fwd = '0;
        lu = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            ra = int'(ra_e[i*AW +: AW]);
            if (ra != 0 && regwrite_m && ra == int'(wa_m)) fwd[2*i +: 2] = 2'b10;
            else if (ra != 0 && regwrite_w && ra == int'(wa_w)) fwd[2*i +: 2] = 2'b01;
            ra = int'(ra_d[i*AW +: AW]);
            if (memtoreg_e && src_valid_d[i] && ra != 0 && ra == int'(wa_e)) lu = 1'b1;
        end
        b = cur_beats();
        mc = (b > 1);
        last = (b == 1);
        {sf, sd, se, fd, fe, fm} = 6'b0;
        if (mc) {sf, sd, se, fm} = 4'b1111;
        else if (branch_taken_e) {fd, fe} = 2'b11;
        else if (lu) {sf, sd, fe} = 3'b111;
        return {fwd, sf, sd, se, fd, fe, fm, last};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rem <= 0;
        else rem <= (cur_beats() > 0) ? cur_beats() - 1 : 0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [10:0] e;
            e = model_out();
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %b expected %b", $time, act, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ra_d = '0; ra_e = '0; src_valid_d = '0; wa_e = '0; wa_m = '0; wa_w = '0;
        memtoreg_e = 0; regwrite_m = 0; regwrite_w = 0; vec_op_e = 0; vl_e = '0;
        branch_taken_e = 0;
    endtask

    task automatic set_lu();
        memtoreg_e = 1; wa_e = 4'd5; ra_d = {4'd5, 4'd0}; src_valid_d = 2'b10;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #2;
        chk("reset_outputs", 32'(act), 32'h0);
        step(); step();
        rst_n = 1;

        // forwarding priority and register-zero exclusion
        ra_e = {4'd0, 4'd3}; wa_m = 3; wa_w = 3; regwrite_m = 1; regwrite_w = 1;
        @(negedge clk); chk("fwd_mem", 32'(forward_e[1:0]), 32'h2);
        step(); regwrite_m = 0;
        @(negedge clk); chk("fwd_wb", 32'(forward_e[1:0]), 32'h1);
        step(); ra_e = {4'd7, 4'd0}; wa_w = 7;
        @(negedge clk); chk("fwd_zero", 32'(forward_e[1:0]), 32'h0);
        chk("fwd_src1", 32'(forward_e[3:2]), 32'h1);
        step(); clear_inputs();

        // load-use
        set_lu();
        @(negedge clk); chk("lu_stall", 32'({stall_f, stall_d, stall_e, flush_e}), 32'hD);
        step(); src_valid_d = 2'b01;
        @(negedge clk); chk("lu_masked", 32'(stall_f), 32'h0);
        step(); wa_e = 0; ra_d = '0; src_valid_d = 2'b11;
        @(negedge clk); chk("lu_r0", 32'(stall_f), 32'h0);

        // branch beats load-use
        step(); set_lu(); branch_taken_e = 1;
        @(negedge clk); chk("br_over_lu", 32'({stall_f, flush_d, flush_e}), 32'h3);
        step(); clear_inputs();

        // 16-element op: three hold cycles then the last beat
        vec_op_e = 1; vl_e = 16;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mb16_hold", 32'({stall_f, stall_d, stall_e, flush_m}), (k < 3) ? 32'hF : 32'h0);
            chk("mb16_last", 32'(ex_last), (k == 3) ? 32'h1 : 32'h0);
            step();
        end
        vec_op_e = 0;
        @(negedge clk); chk("mb16_idle", 32'({stall_e, ex_last}), 32'h0);

        // branch ignored while busy; load-use resolved on the last beat
        step(); vec_op_e = 1; vl_e = 16; set_lu(); branch_taken_e = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) chk("busy_br_ignored", 32'({stall_f, flush_d, flush_e, flush_m}), 32'h9);
            else chk("last_lu", 32'({stall_f, stall_e, flush_e, ex_last}), 32'hB);
            step();
            if (k == 2) branch_taken_e = 0;
        end
        clear_inputs();

        // single-beat ops
        vec_op_e = 1; vl_e = 3;
        @(negedge clk); chk("vl3", 32'({stall_f, ex_last}), 32'h1);
        step(); vl_e = 0;
        @(negedge clk); chk("vl0", 32'({stall_f, ex_last}), 32'h1);
        step(); vec_op_e = 0;

        // reset during the second beat
        vec_op_e = 1; vl_e = 16;
        @(negedge clk);
        step(); #2;
        rst_n = 0; #1;
        chk("rst_abort", 32'({stall_f, stall_d, stall_e, flush_m, ex_last}), 32'h0);
        clear_inputs();
        step(); step();
        rst_n = 1;
        vec_op_e = 1; vl_e = 8;
        @(negedge clk); chk("post_rst_start", 32'(stall_e), 32'h1);
        step(); vec_op_e = 0;
        @(negedge clk); chk("post_rst_last", 32'({stall_e, ex_last}), 32'h1);
        step();

`ifdef VEC_HAZARD_PERF_CNT_EN
        rst_n = 0; #2; rst_n = 1;
        step();
        vec_op_e = 1; vl_e = 16;
        for (int k = 0; k < 4; k++) step();
        clear_inputs();
        set_lu();
        step();
        clear_inputs();
        step(); step();
        chk("perf_stall_cycles", stall_cycles, 32'd4);
        chk("perf_flush_count", flush_count, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_hazard_unit.md
Name: vec_hazard_unit

Overview:
- Parametrised successor to the scalar pipeline hazard unit for the vectorial CPU.
- Generalises forwarding and load-use detection to NSRC source operands and AW-bit register addresses.
- Adds a beat-counter FSM that holds a multi-beat vector op in EX for ceil(VL/LANES) cycles.
- Adds branch-taken flush control. Sits beside the 5-stage datapath and drives stall, flush and forward-select controls.

Parameters:
AW, 4, register address width; register 0 is hard-wired zero and never forwarded or stalled on.
NSRC, 2, source operands per instruction (flattened ports, operand i at bits [i*AW +: AW]).
LANES, 4, vector lanes processed per EX beat.
MAX_VL, 16, maximum vector length; VLW = $clog2(MAX_VL+1).

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
ra_d  in  NSRC*AW  decode-stage source addresses
src_valid_d  in  NSRC  decode source i actually read
ra_e  in  NSRC*AW  execute-stage source addresses
wa_e  in  AW  execute-stage destination
wa_m  in  AW  memory-stage destination
wa_w  in  AW  writeback-stage destination
memtoreg_e  in  1  EX instruction is a load
regwrite_m  in  1  MEM writes register file
regwrite_w  in  1  WB writes register file
vec_op_e  in  1  EX instruction is a vector op
vl_e  in  VLW  vector length of EX instruction
branch_taken_e  in  1  branch resolved taken in EX
forward_e  out  2*NSRC  per-source select: 10=ALUOutM, 01=ResultW, 00=regfile
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
stall_e  out  1  hold ID/EX
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX
flush_m  out  1  bubble into EX/MEM
ex_last  out  1  final beat of a multi-beat vector op

Behaviour:
- Forwarding (comb), per source i:
  - 10 if ra_e[i]==wa_m && regwrite_m && ra_e[i]!=0.
  - Otherwise 01 if ra_e[i]==wa_w && regwrite_w && ra_e[i]!=0.
  - Otherwise 00. MEM has priority over WB.
- Load-use (comb): lu = memtoreg_e && OR over i of (src_valid_d[i] && ra_d[i]==wa_e && ra_d[i]!=0).
- Beats: beats = ceil(vl_e/LANES); vl_e==0 is treated as 1 beat.
- FSM states: IDLE, BUSY. Counter cnt is VLW bits.
  - IDLE and vec_op_e and beats>1: load cnt<=beats-1, go to BUSY. This start cycle is multi-cycle stalling (mc=1).
  - BUSY and cnt>1: cnt<=cnt-1, mc=1.
  - BUSY and cnt==1: ex_last=1, mc=0, go to IDLE.
  - vec_op_e is ignored while in BUSY.
  - ex_last is also 1 in IDLE for a vector op with beats<=1.
- Example, LANES=4, vl=16: mc is high for exactly 3 cycles and ex_last pulses on the 4th.
- Output priority, highest first:
  1. mc: stall_f=stall_d=stall_e=1, flush_m=1, flush_d=flush_e=0. branch_taken_e and lu are ignored.
  2. branch_taken_e: flush_d=flush_e=1, stalls 0.
  3. lu: stall_f=stall_d=1, flush_e=1.
  4. Otherwise all stall/flush outputs 0.
- lu is re-evaluated on the ex_last cycle; a vector load followed by a dependent instruction gets its load-use bubble then.
- Reset (async, rst_n low): state=IDLE, cnt=0, and with all inputs zero every output is 0.
- Reset asserted mid-BUSY aborts the op immediately: stalls drop in the same cycle, with no ex_last.
- All stall/flush/forward outputs are combinational from inputs and FSM state. The FSM adds no latency to forwarding.

Optional Feature:
- Macro: VEC_HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles (32) and flush_count (32).
  - stall_cycles increments every cycle stall_f=1; flush_count increments every cycle flush_e=1 or flush_m=1.
  - Both saturate at 0xFFFFFFFF and clear on rst_n low.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Forward priority: ra_e[0]=3, wa_m=3, wa_w=3, regwrite_m=regwrite_w=1 -> forward_e[1:0]=10; drop regwrite_m -> 01; ra_e[0]=0 -> 00.
- Load-use: memtoreg_e=1, wa_e=5, ra_d[1]=5, src_valid_d=2'b10 -> stall_f=stall_d=flush_e=1 for one cycle; src_valid_d=2'b01 -> no stall.
- Multi-beat: LANES=4, vec_op_e=1, vl_e=16 -> stall_f/d/e and flush_m high 3 cycles, ex_last on cycle 4, then IDLE; vl_e=3 -> no stall, ex_last same cycle.
- Priority: branch_taken_e=1 with lu true -> flush_d=flush_e=1, stall_f=0; branch_taken_e=1 during BUSY -> ignored, stalls held.
- Reset mid-op: start vl_e=16, assert rst_n=0 on beat 2 -> all outputs 0 asynchronously, state IDLE after release.
- With VEC_HAZARD_PERF_CNT_EN: the vl=16 op followed by one load-use -> stall_cycles=4, flush_count=4.
